// File: rtl/shift_frame_pkg.sv
// Shared types and helpers for the serial frame receiver.
package shift_frame_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width: enough bits to hold 0..width-1, never less than one.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Bit counter for one frame: counts strobes 0..WIDTH-1 and wraps on terminal count.
module frame_bit_counter
  import shift_frame_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             co
);

  logic [CNT_W-1:0] r_count;

  assign count = r_count;
  // Terminal count is combinational so the frame completes on this same edge.
  assign co    = en & (r_count == CNT_W'(WIDTH - 1));

  // Clear beats counting; wrap to zero on terminal count.
  always_ff @(posedge clk) begin
    if (rst)       r_count <= '0;
    else if (clr)  r_count <= '0;
    else if (en)   r_count <= co ? '0 : r_count + 1'b1;
  end

endmodule

// File: rtl/shift_frame_rx.sv
// Serial-to-parallel frame receiver with a one-deep output register and overrun flag.
module shift_frame_rx
  import shift_frame_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               MSB_FIRST  = 1,
  parameter int               CONTINUOUS = 1,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0,
  localparam int              CNT_W      = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             si,
  input  logic             init,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] po,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             co,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_po, w_po_shift, r_out_data;
  logic             r_out_valid, r_ovr;
  logic             w_shift_st, w_co, w_cand, w_drop;

  assign w_shift_st = (r_state == SHIFT);

  // Counter runs only on strobes in SHIFT; start restarts the frame count.
  frame_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    (w_shift_st & en),
    .count (bit_cnt),
    .co    (w_co)
  );

  // A restart on the terminal strobe discards the frame rather than completing it.
  assign w_cand = w_co & ~start;
  assign w_drop = w_cand & r_out_valid & ~out_ready;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_po_shift = {r_po[WIDTH-2:0], si};
    end else begin : g_lsb
      assign w_po_shift = {si, r_po[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: start enters SHIFT; a completed frame leaves it unless continuous.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (w_cand && CONTINUOUS == 0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register: init only in IDLE; in SHIFT shift on strobe unless restarting.
  always_ff @(posedge clk) begin
    if (rst)                 r_po <= INIT_VAL;
    else if (!w_shift_st)    begin
      if (init)              r_po <= INIT_VAL;
    end
    else if (en && !start)   r_po <= w_po_shift;
  end

  // Output holding register and sticky overrun (a drop beats a clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      if (w_cand) begin
        if (!r_out_valid || out_ready) begin
          r_out_data  <= w_po_shift;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop)       r_ovr <= 1'b1;
      else if (clr_ovr) r_ovr <= 1'b0;
    end
  end

  assign po        = r_po;
  assign co        = w_co;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = w_shift_st;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_shift_frame_rx.sv
// Bench: two receivers (MSB-first continuous, LSB-first one-shot) against a frame model.
module tb_shift_frame_rx;

  logic clk = 1'b0;
  logic rst, start, en, si, init, out_ready, clr_ovr;

  logic [7:0] a_po, a_od, b_po, b_od;
  logic [2:0] a_bc, b_bc;
  logic       a_co, a_ov, a_busy, a_ovr;
  logic       b_co, b_ov, b_busy, b_ovr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_frame_rx #(.WIDTH(8), .MSB_FIRST(1), .CONTINUOUS(1), .INIT_VAL(8'h00)) dut_a (
    .clk(clk), .rst(rst), .start(start), .en(en), .si(si), .init(init),
    .out_ready(out_ready), .clr_ovr(clr_ovr), .po(a_po), .bit_cnt(a_bc), .co(a_co),
    .out_data(a_od), .out_valid(a_ov), .busy(a_busy), .overrun(a_ovr)
  );

  shift_frame_rx #(.WIDTH(8), .MSB_FIRST(0), .CONTINUOUS(0), .INIT_VAL(8'hC3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .en(en), .si(si), .init(init),
    .out_ready(out_ready), .clr_ovr(clr_ovr), .po(b_po), .bit_cnt(b_bc), .co(b_co),
    .out_data(b_od), .out_valid(b_ov), .busy(b_busy), .overrun(b_ovr)
  );

  // ---------------- frame-level model ----------------
  typedef struct {
    bit         busy;
    int         bits;
    logic [7:0] po;
    logic [7:0] od;
    bit         ov;
    bit         ovr;
  } m_t;

  m_t ma, mb;
  bit m_ok = 1'b0;

  function automatic m_t mstep(input m_t s, input bit msbf, input bit cont, input logic [7:0] initv);
    m_t n;
    bit cand;
    n = s;
    cand = 1'b0;
    if (rst) begin
      n.busy = 0; n.po = initv; n.bits = 0; n.od = 8'h00; n.ov = 0; n.ovr = 0;
      return n;
    end
    if (!s.busy) begin
      if (init)  n.po = initv;
      if (start) n.busy = 1;
    end else if (start) begin
      n.bits = 0;
    end else if (en) begin
      if (msbf) n.po = 8'((int'(s.po) * 2 + int'(si)) % 256);
      else      n.po = 8'(int'(s.po) / 2 + int'(si) * 128);
      if (s.bits == 7) begin
        cand = 1; n.bits = 0;
        if (!cont) n.busy = 0;
      end else begin
        n.bits = s.bits + 1;
      end
    end
    if (cand) begin
      if (!s.ov || out_ready) begin n.od = n.po; n.ov = 1; end
      else n.ovr = 1;
    end else if (s.ov && out_ready) begin
      n.ov = 0;
    end
    if (!(cand && s.ov && !out_ready) && clr_ovr) n.ovr = 0;
    return n;
  endfunction

  always @(posedge clk) begin
    ma = mstep(ma, 1'b1, 1'b1, 8'h00);
    mb = mstep(mb, 1'b0, 1'b0, 8'hC3);
    if (rst) m_ok = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string t, input m_t m, input logic [7:0] p, input logic [2:0] bc,
                          input logic c, input logic [7:0] od, input logic ov, input logic bsy,
                          input logic ovr);
    chk({t, "_po"},  32'(p),   32'(m.po));
    chk({t, "_cnt"}, 32'(bc),  32'(m.bits));
    chk({t, "_co"},  32'(c),   32'(m.busy && en && m.bits == 7));
    chk({t, "_od"},  32'(od),  32'(m.od));
    chk({t, "_ov"},  32'(ov),  32'(m.ov));
    chk({t, "_busy"},32'(bsy), 32'(m.busy));
    chk({t, "_ovr"}, 32'(ovr), 32'(m.ovr));
  endtask

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      cmp_inst("a", ma, a_po, a_bc, a_co, a_od, a_ov, a_busy, a_ovr);
      cmp_inst("b", mb, b_po, b_bc, b_co, b_od, b_ov, b_busy, b_ovr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    start = 0; en = 0; si = 0; init = 0; clr_ovr = 0;
    cyc();
  endtask

  // Start, then 8 bits of w in order w[7]..w[0]; optional en=0 gap after each bit.
  task automatic send_frame(input logic [7:0] w, input bit gaps, input bit rdy_body, input bit rdy_last);
    logic [7:0] wv;
    wv = w;
    out_ready = rdy_body; start = 1; en = 0; cyc();
    start = 0;
    for (int i = 7; i >= 0; i--) begin
      en = 1; si = wv[i];
      if (i == 0) begin
        out_ready = rdy_last;
        #1;
        chk("a_co_last", 32'(a_co), 32'd1);
        chk("b_co_last", 32'(b_co), 32'd1);
      end
      cyc();
      if (gaps && i > 0) begin
        en = 0; cyc();
        chk("a_gap_hold", 32'(a_bc), 32'(8 - i));
      end
    end
    en = 0; si = 0;
  endtask

  initial begin
    rst = 1; start = 0; en = 0; si = 0; init = 0; out_ready = 0; clr_ovr = 0;
    cyc(); cyc();
    chk("rst_a_po",   32'(a_po),   32'h00);
    chk("rst_b_po",   32'(b_po),   32'hC3);
    chk("rst_a_cnt",  32'(a_bc),   32'd0);
    chk("rst_a_ov",   32'(a_ov),   32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_ovr",  32'(a_ovr),  32'd0);
    rst = 0;

    // Basic frame, both bit orders.
    send_frame(8'hA6, 0, 1, 1);
    chk("basic_a_od",  32'(a_od),   32'hA6);
    chk("basic_a_ov",  32'(a_ov),   32'd1);
    chk("basic_b_od",  32'(b_od),   32'h65);
    chk("basic_a_busy",32'(a_busy), 32'd1);
    chk("basic_b_busy",32'(b_busy), 32'd0);
    idle_cyc();

    // init loads in IDLE (b) and is ignored in SHIFT (a).
    init = 1; cyc(); init = 0;
    chk("init_b_po", 32'(b_po), 32'hC3);
    chk("init_a_po", 32'(a_po), 32'hA6);

    // Strobe gaps.
    send_frame(8'hA6, 1, 1, 1);
    chk("gap_a_od", 32'(a_od), 32'hA6);
    idle_cyc();

    // Back-pressure: second frame dropped.
    send_frame(8'hA6, 0, 0, 0);
    chk("bp1_a_od", 32'(a_od), 32'hA6);
    send_frame(8'h3C, 0, 0, 0);
    chk("bp2_a_od",  32'(a_od),  32'hA6);
    chk("bp2_a_ovr", 32'(a_ovr), 32'd1);
    chk("bp2_b_ovr", 32'(b_ovr), 32'd1);
    clr_ovr = 1; cyc(); clr_ovr = 0;
    chk("clr_a_ovr", 32'(a_ovr), 32'd0);

    // Completion while full with out_ready=1 replaces the word.
    send_frame(8'h3C, 0, 0, 1);
    chk("repl_a_od",  32'(a_od),  32'h3C);
    chk("repl_a_ov",  32'(a_ov),  32'd1);
    chk("repl_a_ovr", 32'(a_ovr), 32'd0);
    chk("repl_b_od",  32'(b_od),  32'h3C);

    // Reset mid-frame, then a clean frame.
    out_ready = 1; start = 1; cyc(); start = 0;
    en = 1;
    for (int i = 0; i < 4; i++) begin si = i[0]; cyc(); end
    en = 0; rst = 1; cyc(); rst = 0;
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_cnt",  32'(a_bc),   32'd0);
    send_frame(8'h5A, 0, 1, 1);
    chk("post_rst_a_od", 32'(a_od), 32'h5A);
    chk("post_rst_b_od", 32'(b_od), 32'h5A);

    // Restart mid-frame discards the partial bits.
    start = 1; cyc(); start = 0;
    en = 1; si = 1; cyc(); cyc(); cyc(); en = 0;
    send_frame(8'h3C, 0, 1, 1);
    chk("restart_a_od", 32'(a_od), 32'h3C);
    idle_cyc(); idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
